store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 101 ++++++++++
 tb/tb_store_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: committed-store FIFO that drains to data memory and forwards buffered bytes to loads
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    st_valid,
    input  logic [31:0]             st_addr,
    input  logic [31:0]             st_data,
    input  logic [3:0]              st_be,
    output logic                    st_ready,
    input  logic                    ld_req,
    input  logic [31:0]             ld_addr,
    output logic [31:0]             fwd_data,
    output logic [3:0]              fwd_mask,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    output logic [3:0]              mem_be,
    input  logic                    mem_gnt,
    output logic                    sb_empty,
    output logic [$clog2(DEPTH):0]  sb_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d, idx;
    logic [CW-1:0] count_q, count_d;
    logic [29:0]   addr_q [DEPTH];
    logic [29:0]   addr_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [3:0]    be_q   [DEPTH];
    logic [3:0]    be_d   [DEPTH];
    logic          push, pop;
    logic          unused_lsbs;

    assign unused_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    // status, drain port and handshakes derive from registered state; loads own the memory port
    always_comb begin
        sb_count  = count_q;
        sb_empty  = count_q == '0;
        st_ready  = count_q != CW'(DEPTH);
        mem_we    = !sb_empty && !ld_req;
        mem_addr  = sb_empty ? '0 : {addr_q[head_q], 2'b00};
        mem_wdata = sb_empty ? '0 : data_q[head_q];
        mem_be    = sb_empty ? '0 : be_q[head_q];
        push      = st_valid && st_ready;
        pop       = mem_we && mem_gnt;
    end

    // pointer, occupancy and entry updates; a pushed entry is only visible from the next cycle
    always_comb begin
        head_d  = pop ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        if (push) begin
            addr_d[tail_q] = st_addr[31:2];
            data_d[tail_q] = st_data;
            be_d[tail_q]   = st_be;
        end
    end

    // forwarding walks oldest to youngest so younger lanes overwrite older ones
    always_comb begin
        fwd_data = '0;
        fwd_mask = '0;
        idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q && addr_q[idx] == ld_addr[31:2]) begin
                fwd_mask = fwd_mask | be_q[idx];
                for (int b = 0; b < 4; b++)
                    if (be_q[idx][b]) fwd_data[8*b +: 8] = data_q[idx][8*b +: 8];
            end
        end
    end

    // state register; reset discards every held store
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            addr_q  <= '{default: '0};
            data_q  <= '{default: '0};
            be_q    <= '{default: '0};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and randomized checks of store_buffer against a queue model
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 0, reset;
    logic        st_valid, st_ready, ld_req, mem_we, mem_gnt, sb_empty;
    logic [31:0] st_addr, st_data, ld_addr, fwd_data, mem_addr, mem_wdata;
    logic [3:0]  st_be, fwd_mask, mem_be;
    logic [2:0]  sb_count;

    typedef struct packed {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } ent_t;

    ent_t q[$];
    int total = 0, bad = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_be(st_be), .st_ready(st_ready), .ld_req(ld_req), .ld_addr(ld_addr),
        .fwd_data(fwd_data), .fwd_mask(fwd_mask), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt), .sb_empty(sb_empty),
        .sb_count(sb_count)
    );

    always #5 clk = ~clk;

    // one clock of the reference FIFO: inputs are sampled before the edge, model updated after
    task automatic tick();
        bit   push, pop;
        ent_t e;
        push = st_valid && q.size() != DEPTH;
        pop  = q.size() != 0 && !ld_req && mem_gnt;
        e.a = st_addr[31:2];
        e.d = st_data;
        e.b = st_be;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
        @(negedge clk);
    endtask

    // youngest matching entry owns each lane
    function automatic void model_fwd(input logic [31:0] la, output logic [31:0] d, output logic [3:0] m);
        d = 0;
        m = 0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].a == la[31:2])
                for (int b = 0; b < 4; b++)
                    if (q[i].b[b] && !m[b]) begin
                        m[b] = 1'b1;
                        d[8*b +: 8] = q[i].d[8*b +: 8];
                    end
    endfunction

    task automatic push_in(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        st_valid = 1;
        st_addr  = a;
        st_data  = d;
        st_be    = b;
    endtask

    task automatic test_reset();
        reset = 1; st_valid = 0; st_addr = 0; st_data = 0; st_be = 0;
        ld_req = 0; ld_addr = 0; mem_gnt = 0;
        repeat (2) @(negedge clk);
        #1;
        total++; if ({st_ready, sb_empty, mem_we, sb_count} !== 6'b110_000) begin bad++; $display("FAIL reset_status: got %b want 110000", {st_ready, sb_empty, mem_we, sb_count}); end
        total++; if ({mem_addr, mem_wdata, mem_be, fwd_mask} !== 72'h0) begin bad++; $display("FAIL reset_ports: got %h want 0", {mem_addr, mem_wdata, mem_be, fwd_mask}); end
        reset = 0;
        q.delete();
        @(negedge clk);
        total++; if ({st_ready, sb_empty, mem_we, fwd_mask} !== 7'b1100000) begin bad++; $display("FAIL after_reset: got %b want 1100000", {st_ready, sb_empty, mem_we, fwd_mask}); end
    endtask

    task automatic test_single_store();
        push_in(32'h100, 32'hDEADBEEF, 4'hF);
        mem_gnt = 1;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL single_no_bypass: got %b want 0", mem_we); end
        tick();
        st_valid = 0;
        #1;
        total++; if ({mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 32'h100, 32'hDEADBEEF, 4'hF}) begin bad++; $display("FAIL single_drain: got %h want 1_00000100_deadbeef_f", {mem_we, mem_addr, mem_wdata, mem_be}); end
        tick();
        #1;
        total++; if ({sb_empty, sb_count} !== 4'b1000) begin bad++; $display("FAIL single_empty: got %b want 1000", {sb_empty, sb_count}); end
        mem_gnt = 0;
    endtask

    task automatic test_fill();
        mem_gnt = 0;
        for (int k = 0; k < 4; k++) begin
            push_in(32'h400 + 32'(4 * k), $urandom, 4'hF);
            tick();
        end
        push_in(32'h500, 32'h55555555, 4'hF);
        #1;
        total++; if ({sb_count, st_ready} !== 4'b1000) begin bad++; $display("FAIL fill_full: got %b want 1000", {sb_count, st_ready}); end
        tick();
        st_valid = 0;
        #1;
        total++; if (sb_count !== 3'd4) begin bad++; $display("FAIL fill_drop: got %0d want 4", sb_count); end
        mem_gnt = 1;
        tick();
        mem_gnt = 0;
        #1;
        total++; if ({st_ready, sb_count, mem_addr} !== {1'b1, 3'd3, 32'h404}) begin bad++; $display("FAIL fill_regain: got %h want 3_00000404", {st_ready, sb_count, mem_addr}); end
        mem_gnt = 1;
        repeat (3) tick();
        mem_gnt = 0;
        #1;
        total++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL fill_drain_empty: got %b want 1", sb_empty); end
    endtask

    task automatic test_load_priority();
        push_in(32'h600, 32'hCAFEF00D, 4'h3);
        tick();
        st_valid = 0;
        ld_req = 1;
        mem_gnt = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if ({mem_we, sb_count} !== 4'b0001) begin bad++; $display("FAIL ld_priority_%0d: got %b want 0001", k, {mem_we, sb_count}); end
            tick();
        end
        ld_req = 0;
        #1;
        total++; if ({mem_we, mem_addr} !== {1'b1, 32'h600}) begin bad++; $display("FAIL ld_release: got %h want 1_00000600", {mem_we, mem_addr}); end
        tick();
        #1;
        total++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL ld_empty: got %b want 1", sb_empty); end
        mem_gnt = 0;
    endtask

    task automatic test_forward();
        mem_gnt = 0;
        ld_addr = 32'h200;
        push_in(32'h200, 32'h11223344, 4'hF);
        tick();
        push_in(32'h202, 32'hAABB0000, 4'hC);
        #1;
        total++; if ({fwd_data, fwd_mask} !== {32'h11223344, 4'hF}) begin bad++; $display("FAIL fwd_no_push: got %h want 11223344f", {fwd_data, fwd_mask}); end
        tick();
        st_valid = 0;
        #1;
        total++; if ({fwd_data, fwd_mask} !== {32'hAABB3344, 4'hF}) begin bad++; $display("FAIL fwd_merge: got %h want aabb3344f", {fwd_data, fwd_mask}); end
        ld_addr = 32'h204;
        #1;
        total++; if ({fwd_data, fwd_mask} !== 36'h0) begin bad++; $display("FAIL fwd_miss: got %h want 0", {fwd_data, fwd_mask}); end
        ld_addr = 32'h203;
        #1;
        total++; if ({fwd_data, fwd_mask} !== {32'hAABB3344, 4'hF}) begin bad++; $display("FAIL fwd_lsb_ignored: got %h want aabb3344f", {fwd_data, fwd_mask}); end
        ld_addr = 32'h200;
        mem_gnt = 1;
        #1;
        total++; if ({mem_we, fwd_data, fwd_mask} !== {1'b1, 32'hAABB3344, 4'hF}) begin bad++; $display("FAIL fwd_pop_cycle: got %h want 1aabb3344f", {mem_we, fwd_data, fwd_mask}); end
        tick();
        #1;
        total++; if ({fwd_data, fwd_mask} !== {32'hAABB0000, 4'hC}) begin bad++; $display("FAIL fwd_after_pop: got %h want aabb0000c", {fwd_data, fwd_mask}); end
        tick();
        mem_gnt = 0;
    endtask

    task automatic test_wrap();
        logic [31:0] a[11], d[11];
        for (int k = 0; k < 11; k++) begin
            a[k] = 32'h800 + 32'(16 * k);
            d[k] = $urandom;
        end
        mem_gnt = 0;
        push_in(a[0], d[0], 4'hF);
        tick();
        mem_gnt = 1;
        for (int k = 0; k < 10; k++) begin
            push_in(a[k + 1], d[k + 1], 4'hF);
            #1;
            total++; if ({mem_addr, mem_wdata, sb_count} !== {a[k], d[k], 3'd1}) begin bad++; $display("FAIL wrap_%0d: got %h want %h", k, {mem_addr, mem_wdata, sb_count}, {a[k], d[k], 3'd1}); end
            tick();
        end
        st_valid = 0;
        #1;
        total++; if ({mem_addr, mem_wdata} !== {a[10], d[10]}) begin bad++; $display("FAIL wrap_last: got %h want %h", {mem_addr, mem_wdata}, {a[10], d[10]}); end
        tick();
        mem_gnt = 0;
    endtask

    task automatic test_reset_mid();
        mem_gnt = 0;
        for (int k = 0; k < 3; k++) begin
            push_in(32'hA00 + 32'(4 * k), $urandom, 4'hF);
            tick();
        end
        st_valid = 0;
        #1;
        total++; if (sb_count !== 3'd3) begin bad++; $display("FAIL rstmid_held: got %0d want 3", sb_count); end
        #2 reset = 1;
        #1;
        total++; if ({sb_count, mem_we, sb_empty} !== 5'b00001) begin bad++; $display("FAIL rstmid_clear: got %b want 00001", {sb_count, mem_we, sb_empty}); end
        q.delete();
        @(negedge clk);
        reset = 0;
        mem_gnt = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rstmid_nowrite_%0d: got %b want 0", k, mem_we); end
            tick();
        end
        mem_gnt = 0;
    endtask

    task automatic test_random();
        logic [31:0] ed, ea, ewd;
        logic [3:0]  em, ebe;
        logic        emp;
        for (int c = 0; c < 400; c++) begin
            st_valid = $urandom_range(0, 99) < 60;
            st_addr  = 32'h300 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            st_data  = $urandom;
            st_be    = 4'($urandom);
            ld_req   = $urandom_range(0, 99) < 30;
            ld_addr  = 32'h300 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
            mem_gnt  = $urandom_range(0, 99) < 60;
            #1;
            emp = q.size() == 0;
            ea  = emp ? 32'h0 : {q[0].a, 2'b00};
            ewd = emp ? 32'h0 : q[0].d;
            ebe = emp ? 4'h0 : q[0].b;
            model_fwd(ld_addr, ed, em);
            total++; if ({st_ready, sb_empty, mem_we, sb_count} !== {q.size() != DEPTH, emp, !emp && !ld_req, 3'(q.size())}) begin bad++; $display("FAIL rnd_status_%0d: got %b want %b", c, {st_ready, sb_empty, mem_we, sb_count}, {q.size() != DEPTH, emp, !emp && !ld_req, 3'(q.size())}); end
            total++; if ({mem_addr, mem_wdata, mem_be} !== {ea, ewd, ebe}) begin bad++; $display("FAIL rnd_head_%0d: got %h want %h", c, {mem_addr, mem_wdata, mem_be}, {ea, ewd, ebe}); end
            total++; if ({fwd_data, fwd_mask} !== {ed, em}) begin bad++; $display("FAIL rnd_fwd_%0d: got %h want %h", c, {fwd_data, fwd_mask}, {ed, em}); end
            tick();
        end
        st_valid = 0;
        ld_req = 0;
        mem_gnt = 1;
        repeat (DEPTH) tick();
        mem_gnt = 0;
        #1;
        total++; if (sb_empty !== 1'b1) begin bad++; $display("FAIL rnd_final_empty: got %b want 1", sb_empty); end
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_fill();
        test_load_priority();
        test_forward();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
